// File: rtl/synth_pkg.sv
// Shared synth-chain constants, allocator state encoding
// and the note-to-phase-increment formula.
package synth_pkg;

  localparam int  SAMPLEFREQ  = 31250;
  localparam int  BITDEPTH    = 14;
  localparam int  BITFRACTION = 6;
  localparam int  INC_W       = BITDEPTH + BITFRACTION;
  localparam int  NUM_NOTES   = 128;
  localparam real SEMITONE    = 1.0594630943592953;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    APPLY
  } alloc_state_t;

  // A4 (note 69) = 440 Hz, stepped by equal-tempered semitones
  function automatic int inc_of(int n);
    real f;
    f = 440.0 * real'(1 << (INC_W + 1));
    f = f / real'(SAMPLEFREQ);
    if (n >= 69) begin
      for (int k = 69; k < n; k++) f = f * SEMITONE;
    end else begin
      for (int k = n; k < 69; k++) f = f / SEMITONE;
    end
    return $rtoi(f + 0.5);
  endfunction

endpackage

// File: rtl/voice_allocator_note_rom.sv
// Synchronous-read ROM mapping MIDI note number to
// phase increment, filled at elaboration.
module note_rom
  import synth_pkg::*;
#(
  parameter int INC_WIDTH = INC_W
) (
  input  logic                 clk,
  input  logic [6:0]           addr,
  output logic [INC_WIDTH-1:0] data
);

  logic [INC_WIDTH-1:0] rom [NUM_NOTES];
  logic [INC_WIDTH-1:0] data_d;
  logic [INC_WIDTH-1:0] data_q;

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_rom
    localparam logic [INC_WIDTH-1:0] VAL =
      INC_WIDTH'(inc_of(g));
    assign rom[g] = VAL;
  end

  assign data_d = rom[addr];

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: note events in, per-voice
// gate and pitch increment out, oldest voice stolen.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int INC_WIDTH  = INC_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            note_valid,
  output logic                            note_ready,
  input  logic [6:0]                      note_num,
  input  logic                            note_on,
  input  logic                            panic,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*INC_WIDTH-1:0] pitch_increment
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam logic [RW-1:0] OLDEST = RW'(NUM_VOICES - 1);

  alloc_state_t state_q, state_d;

  logic [6:0] lat_note_q, lat_note_d;
  logic       lat_on_q, lat_on_d;

  logic [NUM_VOICES-1:0]                held_q, held_d;
  logic [NUM_VOICES-1:0][6:0]           note_q, note_d;
  logic [NUM_VOICES-1:0][RW-1:0]        rank_q, rank_d;
  logic [NUM_VOICES-1:0][INC_WIDTH-1:0] inc_q, inc_d;

  logic [INC_WIDTH-1:0] rom_data;
  logic                 accept;
  logic                 hit;
  logic                 any_free;
  logic [RW-1:0]        hit_idx;
  logic [RW-1:0]        free_idx;
  logic [RW-1:0]        old_idx;
  logic [RW-1:0]        tgt_idx;

  note_rom #(
    .INC_WIDTH(INC_WIDTH)
  ) u_rom (
    .clk  (clk),
    .addr (lat_note_q),
    .data (rom_data)
  );

  // Descending scan so the lowest index wins each search
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (held_q[i] && note_q[i] == lat_note_q) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
      end
      if (!held_q[i]) begin
        any_free = 1'b1;
        free_idx = RW'(i);
      end
      if (rank_q[i] == OLDEST) old_idx = RW'(i);
    end
    tgt_idx = any_free ? free_idx : old_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (panic) state_d = IDLE;
  end

  always_comb begin
    note_ready = (state_q == IDLE) && !panic;
    accept     = note_valid && note_ready;
  end

  always_comb begin
    lat_note_d = lat_note_q;
    lat_on_d   = lat_on_q;
    held_d     = held_q;
    note_d     = note_q;
    rank_d     = rank_q;
    inc_d      = inc_q;
    if (accept) begin
      lat_note_d = note_num;
      lat_on_d   = note_on;
    end
    if (state_q == APPLY) begin
      if (lat_on_q && !hit) begin
        held_d[tgt_idx] = 1'b1;
        note_d[tgt_idx] = lat_note_q;
        inc_d[tgt_idx]  = rom_data;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (RW'(i) == tgt_idx)
            rank_d[i] = '0;
          else if (rank_q[i] < rank_q[tgt_idx])
            rank_d[i] = rank_q[i] + 1'b1;
        end
      end else if (!lat_on_q && hit) begin
        held_d[hit_idx] = 1'b0;
      end
    end
    if (panic) held_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_note_q <= '0;
      lat_on_q   <= 1'b0;
      held_q     <= '0;
      note_q     <= '0;
      inc_q      <= '0;
      for (int i = 0; i < NUM_VOICES; i++)
        rank_q[i] <= RW'(i);
    end else begin
      lat_note_q <= lat_note_d;
      lat_on_q   <= lat_on_d;
      held_q     <= held_d;
      note_q     <= note_d;
      rank_q     <= rank_d;
      inc_q      <= inc_d;
    end
  end

  assign gate            = held_q;
  assign pitch_increment = inc_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: timing, stealing,
// note-off, duplicates, throughput, panic and reset.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int IW = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           note_valid;
  logic           note_ready;
  logic [6:0]     note_num;
  logic           note_on;
  logic           panic;
  logic [NV-1:0]  gate;
  logic [NV*IW-1:0] pitch_increment;

  int checks = 0;
  int errors = 0;

  logic [6:0] nl [5] = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67};

  voice_allocator #(
    .NUM_VOICES (NV),
    .INC_WIDTH  (IW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .note_valid      (note_valid),
    .note_ready      (note_ready),
    .note_num        (note_num),
    .note_on         (note_on),
    .panic           (panic),
    .gate            (gate),
    .pitch_increment (pitch_increment)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] pv(int i);
    return pitch_increment[i*IW +: IW];
  endfunction

  function automatic logic [31:0] ranks();
    return 32'(dut.rank_q);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Returns just after the accepting edge
  task automatic send(input logic [6:0] n, input logic on);
    int k;
    note_num   = n;
    note_on    = on;
    note_valid = 1'b1;
    k = 0;
    while (!note_ready && k < 20) begin
      tick();
      k++;
    end
    check("accept_timeout", 32'(k < 20), 32'd1);
    tick();
    note_valid = 1'b0;
  endtask

  task automatic send_done(input logic [6:0] n, input logic on);
    send(n, on);
    repeat (2) tick();
  endtask

  initial begin
    int acc;
    logic hs;
    rst        = 1'b0;
    note_valid = 1'b0;
    note_num   = '0;
    note_on    = 1'b0;
    panic      = 1'b0;

    // Reset state and first note-on latency
    do_reset();
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_pitch_lo", 32'(pitch_increment[31:0]), 32'd0);
    check("rst_pitch_hi", 32'(pitch_increment[79:32]), 32'd0);
    check("rst_ready", 32'(note_ready), 32'd1);
    check("rst_rank", ranks(), 32'he4);
    send(7'd60, 1'b1);
    check("t1_ready_T", 32'(note_ready), 32'd0);
    check("t1_gate_T", 32'(gate), 32'd0);
    tick();
    check("t1_ready_T1", 32'(note_ready), 32'd0);
    check("t1_gate_T1", 32'(gate), 32'd0);
    tick();
    check("t1_ready_T2", 32'(note_ready), 32'd1);
    check("t1_gate_T2", 32'(gate), 32'h1);
    check("t1_pitch0", 32'(pv(0)), 32'd17557);
    check("t1_rank", ranks(), 32'he4);

    // Fill all voices then steal the oldest
    do_reset();
    send_done(7'd60, 1'b1);
    send_done(7'd62, 1'b1);
    check("t2_rank_2", ranks(), 32'he1);
    send_done(7'd64, 1'b1);
    send_done(7'd65, 1'b1);
    check("t2_gate_full", 32'(gate), 32'hf);
    check("t2_rank_full", ranks(), 32'h1b);
    send(7'd69, 1'b1);
    check("t2_gate_T", 32'(gate), 32'hf);
    tick();
    check("t2_gate_T1", 32'(gate), 32'hf);
    tick();
    check("t2_gate_T2", 32'(gate), 32'hf);
    check("t2_steal_pitch", 32'(pv(0)), 32'd29528);
    check("t2_steal_rank", ranks(), 32'h6c);

    // Note-off, then unmatched note-off
    do_reset();
    send_done(7'd60, 1'b1);
    check("t3_gate_on", 32'(gate), 32'h1);
    send_done(7'd60, 1'b0);
    check("t3_gate_off", 32'(gate), 32'h0);
    check("t3_tail_pitch", 32'(pv(0)), 32'd17557);
    send_done(7'd72, 1'b0);
    check("t3_nomatch_ready", 32'(note_ready), 32'd1);
    check("t3_nomatch_gate", 32'(gate), 32'h0);
    check("t3_nomatch_pitch", 32'(pv(0)), 32'd17557);
    check("t3_rank", ranks(), 32'he4);

    // Duplicate note-on is ignored
    do_reset();
    send_done(7'd60, 1'b1);
    send_done(7'd60, 1'b1);
    check("t4_dup_gate", 32'(gate), 32'h1);
    check("t4_dup_pitch1", 32'(pv(1)), 32'd0);
    check("t4_dup_rank", ranks(), 32'he4);
    send_done(7'd81, 1'b1);
    check("t4_81_gate", 32'(gate), 32'h3);
    check("t4_81_pitch1", 32'(pv(1)), 32'd59056);
    check("t4_81_pitch0", 32'(pv(0)), 32'd17557);
    check("t4_81_rank", ranks(), 32'he1);

    // Back-to-back with note_valid held high
    do_reset();
    acc        = 0;
    note_num   = nl[0];
    note_on    = 1'b1;
    note_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check("t5_ready_slot", 32'(note_ready),
            32'((c % 3) == 0));
      hs = note_ready;
      tick();
      if (hs) begin
        acc++;
        note_num = nl[acc];
      end
    end
    note_valid = 1'b0;
    check("t5_accepts", 32'(acc), 32'd4);
    check("t5_gate", 32'(gate), 32'hf);
    check("t5_rank", ranks(), 32'h1b);
    check("t5_pitch0", 32'(pv(0)), 32'd17557);

    // Panic during LOOKUP drops the event
    do_reset();
    send_done(7'd60, 1'b1);
    send_done(7'd62, 1'b1);
    check("t6_gate_pre", 32'(gate), 32'h3);
    send(7'd64, 1'b1);
    panic = 1'b1;
    tick();
    check("t6_gate_panic", 32'(gate), 32'h0);
    for (int c = 0; c < 3; c++) begin
      check("t6_ready_panic", 32'(note_ready), 32'd0);
      tick();
    end
    check("t6_gate_hold", 32'(gate), 32'h0);
    panic = 1'b0;
    #1;
    check("t6_ready_after", 32'(note_ready), 32'd1);
    check("t6_dropped_pitch2", 32'(pv(2)), 32'd0);
    check("t6_kept_pitch0", 32'(pv(0)), 32'd17557);
    check("t6_kept_rank", ranks(), 32'he1);
    send_done(7'd64, 1'b1);
    check("t6_recover_gate", 32'(gate), 32'h1);
    check("t6_recover_rank", ranks(), 32'he4);

    // Asynchronous reset in APPLY
    do_reset();
    send_done(7'd60, 1'b1);
    send(7'd81, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    check("t7_gate", 32'(gate), 32'h0);
    check("t7_pitch0", 32'(pv(0)), 32'd0);
    check("t7_pitch1", 32'(pv(1)), 32'd0);
    check("t7_rank", ranks(), 32'he4);
    check("t7_ready", 32'(note_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("t7_gate_after", 32'(gate), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
